muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Iterative 8x8 unsigned multiply and 8/8 unsigned divide unit built around one shared instance of the 8-bit ripple adder/subtractor (EightBit_Adder_Subtractor).
- Sequences the adder/subtractor for 8 iterations per operation: shift-and-add for multiply, restoring shift-and-subtract for divide.
- Sits beside the adder/subtractor in the lab ALU datapath. A host loads operands with a Start pulse and collects the 16-bit result on Done.

Parameters:
- WIDTH, 8, operand width. Only 8 is supported, matching the adder/subtractor. Iteration count equals WIDTH.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset. Clears all state.
- Start  input  1  operation request. Sampled only while Busy=0.
- Op  input  1  0 = multiply, 1 = divide. Sampled with Start.
- OpA  input  8  multiplicand / dividend. Sampled with Start.
- OpB  input  8  multiplier / divisor. Sampled with Start.
- Busy  output  1  high while iterating.
- Done  output  1  one-cycle pulse when the result becomes valid.
- ResultHi  output  8  product[15:8] or remainder.
- ResultLo  output  8  product[7:0] or quotient.
- DivByZero  output  1  set with Done when Op=1 and OpB=0.

Behaviour:
- Reset values: Busy=0, Done=0, ResultHi=0x00, ResultLo=0x00, DivByZero=0, state=IDLE, iteration count=0.
- States: IDLE and RUN.
- IDLE:
  - Start=1 at an edge latches Op, OpA, OpB, clears the count, and enters RUN.
  - Busy=1 from the next cycle.
- RUN:
  - One iteration per clock, 8 iterations.
  - After the 8th iteration edge: return to IDLE, Done=1 for exactly one cycle, Busy=0, results updated.
- Latency: Start sampled at edge k gives Busy high for cycles k+1..k+8 and Done high in cycle k+9.
- Back-to-back: Start asserted in the Done cycle is accepted at that cycle's closing edge.
- Start while Busy=1 is ignored. Operands are not re-sampled.
- Results and DivByZero hold their values until the next completed operation. They are not cleared on Start.
- Multiply datapath:
  - Initialise Hi=0x00, Lo=multiplier, M=multiplicand.
  - Each iteration: drive adder X=Hi, Y=M, CarryIn=0 (add mode).
  - If Lo[0]=1, {Hi,Lo} <= {CarryOut, Sum, Lo[7:1]}. Otherwise {Hi,Lo} <= {1'b0, Hi, Lo[7:1]}.
  - Final {Hi,Lo} is the 16-bit product.
- Divide datapath (restoring):
  - Initialise R=0x00, Q=dividend, D=divisor.
  - Each iteration: form shifted {msb, Rs} = {R, Q[7]} (9 bits). Drive adder X=Rs, Y=D, CarryIn=1 (subtract mode).
  - Accept when msb | CarryOut (no borrow): R <= Sum, Q <= {Q[6:0], 1}.
  - Reject otherwise: R <= Rs, Q <= {Q[6:0], 0}.
  - Final ResultHi=R (remainder), ResultLo=Q (quotient).
- Divide by zero: the algorithm runs unchanged and yields quotient=0xFF, remainder=dividend. DivByZero=1 with Done.
- The adder/subtractor is combinational. Its inputs are driven only from the internal registers, and its outputs are captured only in RUN.
- Reset mid-operation: immediate return to reset values. No Done is generated, and partial results are discarded.

Decomposition:
- Shared package:
  - OP_MUL=1'b0, OP_DIV=1'b1.
  - State encodings ST_IDLE, ST_RUN.
  - ITER_COUNT=8.
  - Count width 4 bits.
- Sub-module: the existing EightBit_Adder_Subtractor, instantiated once. Its CarryIn doubles as the add/subtract select.
- FSM, counter and shift registers stay in muldiv_sequencer.

Test Plan:
- Multiply: Op=0, OpA=13, OpB=11, Start. Done in cycle k+9 with ResultHi=0x00, ResultLo=0x8F, DivByZero=0.
- Multiply corner: OpA=0xFF, OpB=0xFF. Result 0xFE01. Then OpA=0x00, OpB=0xA5 gives 0x0000.
- Divide: Op=1, OpA=200, OpB=7. ResultLo=0x1C (28), ResultHi=0x04. Also OpA=5, OpB=9 gives Q=0x00, R=0x05.
- Divide by zero: OpA=0x5A, OpB=0. ResultLo=0xFF, ResultHi=0x5A, DivByZero=1.
- Handshake:
  - Start re-asserted with new operands at cycle k+3 changes nothing.
  - Start in the Done cycle launches a second operation whose Done falls 9 cycles later.
- Reset at cycle k+4 mid-multiply: Busy, Done and results all 0 immediately, no Done pulse. A new 3x4 afterwards gives 0x000C.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg
//   Shared definitions for the iterative multiply/divide sequencer:
//   operation codes, FSM state encoding, iteration count and the width
//   of the iteration counter.
package muldiv_sequencer_pkg;

  // Operation select as sampled from the Op input.
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Sequencer states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seqState_t;

  // One adder/subtractor pass per operand bit.
  localparam int ITER_COUNT = 8;
  localparam int COUNT_W    = 4;

  typedef logic [COUNT_W-1:0] count_t;

  // Counter value during the final iteration.
  localparam count_t LAST_ITER = count_t'(ITER_COUNT - 1);

endpackage

// File: rtl/muldiv_sequencer_addsub.sv
// EightBit_Adder_Subtractor
//   Combinational 8-bit ripple-carry adder/subtractor.
//   CarryIn=0 : Sum = X + Y,       CarryOut = carry out of bit 7.
//   CarryIn=1 : Sum = X - Y,       CarryOut = 1 when no borrow (X >= Y).
//   Subtraction is X + ~Y + 1, so CarryIn both selects the mode and
//   supplies the +1 of the two's complement.
// Ports:
//   X, Y      8-bit operands
//   CarryIn   0 = add, 1 = subtract
//   Sum       8-bit result
//   CarryOut  carry / not-borrow
module EightBit_Adder_Subtractor (
  input  logic [7:0] X,
  input  logic [7:0] Y,
  input  logic       CarryIn,
  output logic [7:0] Sum,
  output logic       CarryOut
);

  logic [7:0] yEff;
  logic [8:0] carry;

  assign yEff     = Y ^ {8{CarryIn}};
  assign carry[0] = CarryIn;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : gFullAdder
      assign Sum[gi]     = X[gi] ^ yEff[gi] ^ carry[gi];
      assign carry[gi+1] = (X[gi] & yEff[gi]) | (carry[gi] & (X[gi] ^ yEff[gi]));
    end
  endgenerate

  assign CarryOut = carry[8];

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative 8x8 unsigned multiplier and 8/8 unsigned restoring divider
//   sharing one EightBit_Adder_Subtractor. A Start pulse while idle latches
//   the operands; eight iterations later Done pulses for one cycle and the
//   16-bit result appears on ResultHi/ResultLo, where it is held until the
//   next operation completes.
// Ports:
//   Clk        rising-edge clock
//   Reset      asynchronous active-high reset
//   Start      operation request, honoured only while Busy=0
//   Op         0 = multiply, 1 = divide (sampled with Start)
//   OpA        multiplicand / dividend   (sampled with Start)
//   OpB        multiplier / divisor      (sampled with Start)
//   Busy       high while iterating
//   Done       one-cycle completion pulse
//   ResultHi   product[15:8] or remainder
//   ResultLo   product[7:0]  or quotient
//   DivByZero  set with Done for a divide by zero
module muldiv_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ResultHi,
  output logic [WIDTH-1:0] ResultLo,
  output logic             DivByZero
);

  import muldiv_sequencer_pkg::*;

  // Working registers.
  //   multiply: hiReg = partial product high, loReg = multiplier being
  //             shifted out / product low, mReg = multiplicand
  //   divide:   hiReg = partial remainder, loReg = dividend being shifted
  //             out / quotient shifted in, mReg = divisor
  seqState_t        state;
  count_t           countReg;
  logic             opReg;
  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] loReg;
  logic [WIDTH-1:0] mReg;

  // Adder/subtractor connections.
  logic [WIDTH-1:0] adderX;
  logic [WIDTH-1:0] adderSum;
  logic             adderCout;

  // Remainder shifted left by one with the next dividend bit brought in.
  // The bit shifted out of the top is kept as the 9th bit of the minuend.
  logic [WIDTH-1:0] remShift;
  logic             remMsb;

  // Register values after the current iteration.
  logic [WIDTH-1:0] iterHi;
  logic [WIDTH-1:0] iterLo;
  logic             divAccept;

  assign remShift = {hiReg[WIDTH-2:0], loReg[WIDTH-1]};
  assign remMsb   = hiReg[WIDTH-1];

  // The adder only ever sees register outputs; the mode bit comes from
  // the latched operation, so CarryIn=1 selects subtract for divide.
  assign adderX = (opReg == OP_DIV) ? remShift : hiReg;

  EightBit_Adder_Subtractor uAddSub (
    .X        (adderX),
    .Y        (mReg),
    .CarryIn  (opReg),
    .Sum      (adderSum),
    .CarryOut (adderCout)
  );

  // A set msb means the 9-bit minuend is at least 256 and therefore
  // larger than any divisor, so the subtraction is accepted even though
  // the 8-bit subtractor reports a borrow. The 8-bit Sum is still exact
  // because the true difference is below the divisor.
  assign divAccept = remMsb | adderCout;

  always_comb begin
    iterHi = hiReg;
    iterLo = loReg;
    if (opReg == OP_DIV) begin
      iterHi = divAccept ? adderSum : remShift;
      iterLo = {loReg[WIDTH-2:0], divAccept};
    end else begin
      if (loReg[0]) begin
        // {Hi,Lo} <= {CarryOut, Sum, Lo[7:1]}
        iterHi = {adderCout, adderSum[WIDTH-1:1]};
        iterLo = {adderSum[0], loReg[WIDTH-1:1]};
      end else begin
        // {Hi,Lo} <= {0, Hi, Lo[7:1]}
        iterHi = {1'b0, hiReg[WIDTH-1:1]};
        iterLo = {hiReg[0], loReg[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      countReg  <= '0;
      opReg     <= OP_MUL;
      hiReg     <= '0;
      loReg     <= '0;
      mReg      <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      ResultHi  <= '0;
      ResultLo  <= '0;
      DivByZero <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            opReg    <= Op;
            hiReg    <= '0;
            // Multiply shifts the multiplier (OpB) out of Lo and adds the
            // multiplicand (OpA); divide shifts the dividend (OpA) out of
            // Lo and subtracts the divisor (OpB).
            loReg    <= (Op == OP_DIV) ? OpA : OpB;
            mReg     <= (Op == OP_DIV) ? OpB : OpA;
            countReg <= '0;
            Busy     <= 1'b1;
            state    <= ST_RUN;
          end
        end

        ST_RUN: begin
          hiReg    <= iterHi;
          loReg    <= iterLo;
          countReg <= countReg + count_t'(1);
          if (countReg == LAST_ITER) begin
            state     <= ST_IDLE;
            Busy      <= 1'b0;
            Done      <= 1'b1;
            ResultHi  <= iterHi;
            ResultLo  <= iterLo;
            DivByZero <= (opReg == OP_DIV) && (mReg == '0);
          end
        end

        default: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic       Op;
  logic [7:0] OpA;
  logic [7:0] OpB;
  logic       Busy;
  logic       Done;
  logic [7:0] ResultHi;
  logic [7:0] ResultLo;
  logic       DivByZero;

  int checks;
  int failures;

  muldiv_sequencer #(.WIDTH(8)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Op        (Op),
    .OpA       (OpA),
    .OpB       (OpB),
    .Busy      (Busy),
    .Done      (Done),
    .ResultHi  (ResultHi),
    .ResultLo  (ResultLo),
    .DivByZero (DivByZero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: plain arithmetic on the operation definition.
  function automatic logic [16:0] model(input logic op, input logic [7:0] a, input logic [7:0] b);
    int unsigned ai, bi;
    ai = a;
    bi = b;
    if (op == 1'b0) return {1'b0, 16'(ai * bi)};
    if (bi == 0)    return {1'b1, a, 8'hFF};
    return {1'b0, 8'(ai % bi), 8'(ai / bi)};
  endfunction

  // Called from a negedge: holds Start across exactly one rising edge.
  task automatic launch(input logic op, input logic [7:0] a, input logic [7:0] b);
    Start = 1'b1;
    Op    = op;
    OpA   = a;
    OpB   = b;
    @(posedge Clk);
    #1;
    Start = 1'b0;
  endtask

  // Counts negedges until Done (lat = -1 on timeout) and Busy cycles before it.
  task automatic waitDone(output int lat, output int busyCnt);
    lat     = -1;
    busyCnt = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge Clk);
      if (Done) begin
        lat = i;
        break;
      end
      if (Busy) busyCnt++;
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    Start = 1'b0;
    Op    = 1'b0;
    OpA   = 8'h00;
    OpB   = 8'h00;
    repeat (2) @(negedge Clk);
    checks++;
    if ({Busy, Done, ResultHi, ResultLo, DivByZero} !== 19'h0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b done=%b res=%h%h dbz=%b required all zero",
               Busy, Done, ResultHi, ResultLo, DivByZero);
    end
    Reset = 1'b0;
    @(negedge Clk);
    $display("txn reset: busy=%b done=%b res=%h%h", Busy, Done, ResultHi, ResultLo);
  endtask

  // Directed operations with full latency, Busy-width and result checks.
  task automatic test_directed;
    logic       ops[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] as[6]  = '{8'd13, 8'hFF, 8'h00, 8'd200, 8'd5, 8'h5A};
    logic [7:0] bs[6]  = '{8'd11, 8'hFF, 8'hA5, 8'd7, 8'd9, 8'h00};
    logic [16:0] exp[6] = '{17'h0008F, 17'h0FE01, 17'h00000, 17'h0041C, 17'h00500, 17'h15AFF};
    int lat, busyCnt;
    for (int t = 0; t < 6; t++) begin
      launch(ops[t], as[t], bs[t]);
      waitDone(lat, busyCnt);
      checks++;
      if (lat !== 9) begin
        failures++;
        $display("FAIL directed_latency[%0d]: got %0d required 9", t, lat);
      end
      checks++;
      if (busyCnt !== 8 || Busy !== 1'b0) begin
        failures++;
        $display("FAIL directed_busy[%0d]: got %0d busy cycles, busy at done=%b required 8 and 0",
                 t, busyCnt, Busy);
      end
      checks++;
      if ({DivByZero, ResultHi, ResultLo} !== exp[t]) begin
        failures++;
        $display("FAIL directed_result[%0d]: got %h required %h", t,
                 {DivByZero, ResultHi, ResultLo}, exp[t]);
      end
      $display("txn directed op=%b a=%h b=%h -> hi=%h lo=%h dbz=%b lat=%0d",
               ops[t], as[t], bs[t], ResultHi, ResultLo, DivByZero, lat);
      @(negedge Clk);
      checks++;
      if (Done !== 1'b0 || {DivByZero, ResultHi, ResultLo} !== exp[t]) begin
        failures++;
        $display("FAIL directed_hold[%0d]: got done=%b res=%h required done=0 res=%h", t,
                 Done, {DivByZero, ResultHi, ResultLo}, exp[t]);
      end
    end
  endtask

  task automatic test_random;
    logic        op;
    logic [7:0]  a, b;
    logic [16:0] exp;
    int lat, busyCnt;
    for (int t = 0; t < 30; t++) begin
      op = 1'($urandom_range(0, 1));
      a  = 8'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      exp = model(op, a, b);
      launch(op, a, b);
      waitDone(lat, busyCnt);
      checks++;
      if (lat !== 9 || {DivByZero, ResultHi, ResultLo} !== exp) begin
        failures++;
        $display("FAIL random[%0d]: op=%b a=%h b=%h got lat=%0d res=%h required lat=9 res=%h",
                 t, op, a, b, lat, {DivByZero, ResultHi, ResultLo}, exp);
      end
      $display("txn random op=%b a=%h b=%h -> hi=%h lo=%h dbz=%b", op, a, b,
               ResultHi, ResultLo, DivByZero);
      @(negedge Clk);
    end
  endtask

  // Start re-asserted during RUN with different operands must be ignored.
  task automatic test_start_ignored;
    int lat;
    launch(1'b0, 8'd13, 8'd11);
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge Clk);
      if (i == 2) begin
        Start = 1'b1;
        Op    = 1'b1;
        OpA   = 8'd99;
        OpB   = 8'd3;
      end else begin
        Start = 1'b0;
      end
      if (Done) begin
        lat = i;
        break;
      end
    end
    Start = 1'b0;
    checks++;
    if (lat !== 9 || {DivByZero, ResultHi, ResultLo} !== 17'h0008F) begin
      failures++;
      $display("FAIL start_ignored: got lat=%0d res=%h required lat=9 res=0008f",
               lat, {DivByZero, ResultHi, ResultLo});
    end
    $display("txn start_ignored -> hi=%h lo=%h lat=%0d", ResultHi, ResultLo, lat);
    @(negedge Clk);
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      failures++;
      $display("FAIL start_ignored_idle: got busy=%b done=%b required 0 0", Busy, Done);
    end
  endtask

  // Start in the Done cycle launches a second operation immediately.
  task automatic test_back_to_back;
    logic [16:0] exp1, exp2;
    int lat, busyCnt;
    exp1 = model(1'b1, 8'd250, 8'd16);
    exp2 = model(1'b0, 8'd37, 8'd201);
    launch(1'b1, 8'd250, 8'd16);
    waitDone(lat, busyCnt);
    checks++;
    if (lat !== 9 || {DivByZero, ResultHi, ResultLo} !== exp1) begin
      failures++;
      $display("FAIL b2b_first: got lat=%0d res=%h required lat=9 res=%h",
               lat, {DivByZero, ResultHi, ResultLo}, exp1);
    end
    launch(1'b0, 8'd37, 8'd201);
    waitDone(lat, busyCnt);
    checks++;
    if (lat !== 9 || busyCnt !== 8 || {DivByZero, ResultHi, ResultLo} !== exp2) begin
      failures++;
      $display("FAIL b2b_second: got lat=%0d busy=%0d res=%h required lat=9 busy=8 res=%h",
               lat, busyCnt, {DivByZero, ResultHi, ResultLo}, exp2);
    end
    $display("txn back_to_back -> hi=%h lo=%h lat=%0d", ResultHi, ResultLo, lat);
    @(negedge Clk);
  endtask

  // Asynchronous reset mid-multiply clears everything at once, no Done follows.
  task automatic test_reset_midop;
    int sawDone;
    int lat, busyCnt;
    launch(1'b0, 8'hC3, 8'h77);
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    #1;
    checks++;
    if ({Busy, Done, ResultHi, ResultLo, DivByZero} !== 19'h0) begin
      failures++;
      $display("FAIL reset_midop_clear: got busy=%b done=%b res=%h%h dbz=%b required all zero",
               Busy, Done, ResultHi, ResultLo, DivByZero);
    end
    @(negedge Clk);
    Reset = 1'b0;
    sawDone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      if (Done || Busy) sawDone++;
    end
    checks++;
    if (sawDone !== 0) begin
      failures++;
      $display("FAIL reset_midop_nodone: got %0d active cycles required 0", sawDone);
    end
    launch(1'b0, 8'd3, 8'd4);
    waitDone(lat, busyCnt);
    checks++;
    if (lat !== 9 || {DivByZero, ResultHi, ResultLo} !== 17'h0000C) begin
      failures++;
      $display("FAIL reset_midop_after: got lat=%0d res=%h required lat=9 res=0000c",
               lat, {DivByZero, ResultHi, ResultLo});
    end
    $display("txn reset_midop then 3x4 -> hi=%h lo=%h", ResultHi, ResultLo);
    @(negedge Clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
